// File: rtl/mdiv_host_seq_if.sv
// Core-side bus between the host sequencer and the MINV_MDIV core.
// master = sequencer (loads, start, read strobes); slave = core.
interface mdiv_host_seq_if;
   logic [31:0] datain;
   logic        loada;
   logic        loadb;
   logic        loadp;
   logic        minv_mdiv;
   logic        minv_mdiv_en;
   logic        outx1;
   logic        outx2;
   logic [31:0] regx1out;
   logic [31:0] regx2out;
   logic        minv_mdiv_rdy;
   logic        minv_mdiv_flag;

   modport master (
      output datain, loada, loadb, loadp,
      output minv_mdiv, minv_mdiv_en, outx1, outx2,
      input  regx1out, regx2out,
      input  minv_mdiv_rdy, minv_mdiv_flag
   );

   modport slave (
      input  datain, loada, loadb, loadp,
      input  minv_mdiv, minv_mdiv_en, outx1, outx2,
      output regx1out, regx2out,
      output minv_mdiv_rdy, minv_mdiv_flag
   );
endinterface

// File: rtl/mdiv_host_seq.sv
// Host sequencer for MINV_MDIV: streams p, a, (b) 32 bits per cycle,
// fires the core, waits for ready with a watchdog and drains the result.
// Ports: clk/rst; start/mode/op_a/op_b/op_p host request; busy/done/err/
// result host status; core = core-side bus (mdiv_host_seq_if.master).
module mdiv_host_seq #(
   parameter int WORDS   = 8,
   parameter int TIMEOUT = 4096
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  mode,
   input  logic [32*WORDS-1:0]   op_a,
   input  logic [32*WORDS-1:0]   op_b,
   input  logic [32*WORDS-1:0]   op_p,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [32*WORDS-1:0]   result,
   mdiv_host_seq_if.master       core
);

   localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int OW = 32 * WORDS;

   localparam logic [CW-1:0] CNT_LAST = CW'(WORDS - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LD_P = 3'd1;
   localparam logic [2:0] S_LD_A = 3'd2;
   localparam logic [2:0] S_LD_B = 3'd3;
   localparam logic [2:0] S_GO   = 3'd4;
   localparam logic [2:0] S_WAIT = 3'd5;
   localparam logic [2:0] S_RD   = 3'd6;
   localparam logic [2:0] S_FIN  = 3'd7;

   logic [2:0]    state;
   logic [2:0]    nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] nxt_cnt;
   logic [CW-1:0] cnt_inc;
   logic          cnt_last;
   logic [TW-1:0] tcnt;
   logic          tmo;
   logic          sel;
   logic          nxt_sel;
   logic          minv_q;
   logic [OW-1:0] a_q;
   logic [OW-1:0] b_q;
   logic [OW-1:0] p_q;
   logic [OW-1:0] src;
   logic          accept;

   assign accept   = (state == S_IDLE) && start;
   assign cnt_last = (cnt == CNT_LAST);
   assign cnt_inc  = cnt_last ? '0 : cnt + 1'b1;

   assign core.minv_mdiv = minv_q;

   always_comb begin
      nxt     = state;
      nxt_cnt = cnt;
      tmo     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               nxt     = S_LD_P;
               nxt_cnt = '0;
            end
         end
         S_LD_P: begin
            nxt_cnt = cnt_inc;
            if (cnt_last) nxt = S_LD_A;
         end
         S_LD_A: begin
            nxt_cnt = cnt_inc;
            if (cnt_last) nxt = minv_q ? S_GO : S_LD_B;
         end
         S_LD_B: begin
            nxt_cnt = cnt_inc;
            if (cnt_last) nxt = S_GO;
         end
         S_GO: nxt = S_WAIT;
         S_WAIT: begin
            // tcnt==0 is the first WAIT cycle: a ready left over
            // from the previous job must not be taken.
            if ((tcnt != '0) && core.minv_mdiv_rdy) begin
               nxt = S_RD;
            end else if (tcnt == TMO_LAST) begin
               nxt = S_FIN;
               tmo = 1'b1;
            end
         end
         S_RD: begin
            nxt_cnt = cnt_inc;
            if (cnt_last) nxt = S_FIN;
         end
         S_FIN:   nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end

   // Operand feeding the next load cycle; on the accepting edge the
   // latch is not yet written, so p comes straight from the port.
   always_comb begin
      src = '0;
      case (nxt)
         S_LD_P:  src = (state == S_IDLE) ? op_p : p_q;
         S_LD_A:  src = a_q;
         S_LD_B:  src = b_q;
         default: src = '0;
      endcase
   end

   assign nxt_sel = (state == S_WAIT) ? core.minv_mdiv_flag : sel;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= S_IDLE;
         cnt               <= '0;
         tcnt              <= '0;
         sel               <= 1'b0;
         minv_q            <= 1'b0;
         a_q               <= '0;
         b_q               <= '0;
         p_q               <= '0;
         busy              <= 1'b0;
         done              <= 1'b0;
         err               <= 1'b0;
         result            <= '0;
         core.datain       <= '0;
         core.loada        <= 1'b0;
         core.loadb        <= 1'b0;
         core.loadp        <= 1'b0;
         core.minv_mdiv_en <= 1'b0;
         core.outx1        <= 1'b0;
         core.outx2        <= 1'b0;
      end else begin
         state <= nxt;
         cnt   <= nxt_cnt;
         sel   <= nxt_sel;

         if (accept) begin
            a_q    <= op_a;
            b_q    <= op_b;
            p_q    <= op_p;
            minv_q <= mode;
            err    <= 1'b0;
         end else if (nxt == S_IDLE) begin
            minv_q <= 1'b0;
         end

         if (tmo) err <= 1'b1;

         if (state == S_GO) tcnt <= '0;
         else if (state == S_WAIT) tcnt <= tcnt + 1'b1;

         if (state == S_RD)
            result[{cnt, 5'd0} +: 32] <= sel ? core.regx2out
                                             : core.regx1out;

         busy              <= (nxt != S_IDLE);
         done              <= (nxt == S_FIN);
         core.loadp        <= (nxt == S_LD_P);
         core.loada        <= (nxt == S_LD_A);
         core.loadb        <= (nxt == S_LD_B);
         core.minv_mdiv_en <= (nxt == S_GO);
         core.outx1        <= (nxt == S_RD) && !nxt_sel;
         core.outx2        <= (nxt == S_RD) && nxt_sel;
         core.datain       <= src[{nxt_cnt, 5'd0} +: 32];
      end
   end

endmodule

// File: tb/tb_mdiv_host_seq.sv
// Self-checking bench for mdiv_host_seq with a behavioural core model.
// Random and directed jobs are checked cycle by cycle against a schedule.
module tb_mdiv_host_seq;
   localparam int W  = 8;
   localparam int TO = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         mode;
   logic [255:0] op_a;
   logic [255:0] op_b;
   logic [255:0] op_p;
   logic [255:0] result;
   logic         busy;
   logic         done;
   logic         err;

   int checks = 0;
   int errors = 0;

   logic [255:0] last_res  = '0;
   logic [255:0] cap_a     = '0;
   logic [255:0] cap_b     = '0;
   logic [255:0] cap_p     = '0;
   logic [255:0] x1r       = '0;
   logic [255:0] x2r       = '0;
   logic [255:0] force_val = '0;
   logic [255:0] core_r;
   logic         force_en  = 1'b0;
   logic         flag_drv  = 1'b0;
   logic         rdy_drv   = 1'b0;

   int primes[7] = '{7, 11, 13, 101, 251, 509, 997};

   always #5 clk = ~clk;

   mdiv_host_seq_if cif();

   mdiv_host_seq #(.WORDS(W), .TIMEOUT(TO)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .mode   (mode),
      .op_a   (op_a),
      .op_b   (op_b),
      .op_p   (op_p),
      .busy   (busy),
      .done   (done),
      .err    (err),
      .result (result),
      .core   (cif)
   );

   assign cif.regx1out       = x1r[31:0];
   assign cif.regx2out       = x2r[31:0];
   assign cif.minv_mdiv_rdy  = rdy_drv;
   assign cif.minv_mdiv_flag = flag_drv;

   // Small operands: true modular arithmetic; wide ones: a fixed mix.
   function automatic logic [255:0] fref(input logic [255:0] a,
                                         input logic [255:0] b,
                                         input logic [255:0] p,
                                         input logic inv);
      longint pp, aa, bb, x;
      logic [255:0] r;
      x = 0;
      if (p > 256'd1 && p < 256'd1024 && a < p && (inv || b < p)) begin
         pp = longint'(p[31:0]);
         aa = longint'(a[31:0]);
         bb = inv ? 64'sd0 : longint'(b[31:0]);
         for (longint i = 1; i < pp; i++)
            if ((aa * i) % pp == 1) x = i;
         r = inv ? 256'(x) : 256'((bb * x) % pp);
      end else begin
         r = a ^ {p[31:0], p[255:32]}
               ^ (inv ? 256'd0 : {b[127:0], b[255:128]});
      end
      return r;
   endfunction

   always_comb core_r = force_en ? force_val
                        : fref(cap_a, cap_b, cap_p, cif.minv_mdiv);

   always @(posedge clk) begin
      if (cif.loadp) cap_p <= {cif.datain, cap_p[255:32]};
      if (cif.loada) cap_a <= {cif.datain, cap_a[255:32]};
      if (cif.loadb) cap_b <= {cif.datain, cap_b[255:32]};
      if (cif.minv_mdiv_en) begin
         x1r <= flag_drv ? ~core_r : core_r;
         x2r <= flag_drv ? core_r : ~core_r;
      end else begin
         if (cif.outx1) x1r <= x1r >> 32;
         if (cif.outx2) x2r <= x2r >> 32;
      end
   end

   task automatic check(input string tag,
                        input logic [255:0] got,
                        input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_ctl"},
            256'({busy, done, err, cif.loadp, cif.loada, cif.loadb,
                  cif.minv_mdiv_en, cif.outx1, cif.outx2, cif.minv_mdiv}),
            256'd0);
      check({tag, "_dat"}, 256'(cif.datain), 256'd0);
      check({tag, "_res"}, result, 256'd0);
   endtask

   // One job from a negedge. rdy_c: first cycle with rdy high (0=never);
   // gl: cycle with an ignored start; rc: cycle with a reset pulse.
   task automatic run_op(input logic md, input logic [255:0] a,
                         input logic [255:0] b, input logic [255:0] p,
                         input logic flg, input int rdy_c,
                         input int gl, input int rc);
      int base, w, fin, rd0, c;
      bit tmo, lp, la, lb, rd;
      logic [7:0] ev, av;
      logic [31:0] ed;
      logic [255:0] er;
      base = md ? 17 : 25;
      w = rdy_c - base;
      if (w < 2) w = 2;
      tmo = (rdy_c == 0) || (w > TO);
      rd0 = base + w + 1;
      fin = tmo ? base + TO + 1 : rd0 + W;
      er = tmo ? last_res : (force_en ? force_val : fref(a, b, p, md));
      start = 1'b1;
      mode = md;
      op_a = a;
      op_b = b;
      op_p = p;
      flag_drv = flg;
      rdy_drv = 1'b0;
      @(negedge clk);
      start = 1'b0;
      mode = ~md;
      op_a = ~a;
      op_b = ~b;
      op_p = ~p;
      c = 1;
      forever begin
         lp = (c >= 1) && (c <= 8);
         la = (c >= 9) && (c <= 16);
         lb = !md && (c >= 17) && (c <= 24);
         rd = !tmo && (c >= rd0) && (c < rd0 + W);
         ev = {c <= fin, c == fin, lp, la, lb, c == base,
               rd && !flg, rd && flg};
         av = {busy, done, cif.loadp, cif.loada, cif.loadb,
               cif.minv_mdiv_en, cif.outx1, cif.outx2};
         check($sformatf("ctl@%0d", c), 256'(av), 256'(ev));
         ed = lp ? p[32*(c-1) +: 32] :
              la ? a[32*(c-9) +: 32] :
              lb ? b[32*(c-17) +: 32] : 32'd0;
         check($sformatf("dat@%0d", c), 256'(cif.datain), 256'(ed));
         check($sformatf("err@%0d", c), 256'(err),
               256'((c >= fin) ? tmo : 1'b0));
         if (c <= fin)
            check($sformatf("mode@%0d", c), 256'(cif.minv_mdiv),
                  256'(md));
         if (c == fin) check("result", result, er);
         if (c == rc) begin
            #2 rst = 1'b1;
            #1 check_idle("async_rst");
            #1 rst = 1'b0;
            start = 1'b0;
            rdy_drv = 1'b0;
            last_res = '0;
            @(negedge clk);
            check_idle("post_rst");
            return;
         end
         if (c == fin + 1) break;
         start = (c == gl);
         rdy_drv = (rdy_c != 0) && (c >= rdy_c) && (c < fin);
         @(negedge clk);
         c++;
      end
      rdy_drv = 1'b0;
      start = 1'b0;
      last_res = er;
   endtask

   function automatic logic [255:0] rnd256();
      logic [255:0] v;
      for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
      return v;
   endfunction

   initial begin
      logic [255:0] ra, rb, rp;
      logic md, fl;
      int pr, rc_sel, base;
      rst = 1'b1;
      start = 1'b0;
      mode = 1'b0;
      op_a = '0;
      op_b = '0;
      op_p = '0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      rst = 1'b0;
      @(negedge clk);

      run_op(1'b1, 256'd3, 256'd0, 256'd7, 1'b0, 22, 0, 0);
      run_op(1'b0, 256'd3, 256'd4, 256'd7, 1'b0, 30, 0, 0);

      force_en = 1'b1;
      for (int k = 0; k < 8; k++)
         force_val[32*k +: 32] = 32'h11111111 * (k + 1);
      run_op(1'b1, rnd256(), rnd256(), rnd256(), 1'b1, 20, 0, 0);
      force_en = 1'b0;

      run_op(1'b1, 256'd5, 256'd0, 256'd11, 1'b1, 17, 0, 0);
      run_op(1'b0, 256'd3, 256'd4, 256'd7, 1'b0, 0, 0, 0);
      run_op(1'b0, 256'd3, 256'd4, 256'd7, 1'b0, 29, 0, 0);
      run_op(1'b0, rnd256(), rnd256(), rnd256(), 1'b0, 30, 5, 13);

      for (int n = 0; n < 24; n++) begin
         md = 1'($urandom_range(0, 1));
         fl = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) begin
            pr = primes[$urandom_range(0, 6)];
            rp = 256'(pr);
            ra = 256'($urandom_range(1, pr - 1));
            rb = 256'($urandom_range(0, pr - 1));
         end else begin
            ra = rnd256();
            rb = rnd256();
            rp = rnd256();
         end
         base = md ? 17 : 25;
         rc_sel = int'($urandom_range(0, 9));
         run_op(md, ra, rb, rp, fl,
                (rc_sel == 0) ? 0 : base + int'($urandom_range(0, 18)),
                int'($urandom_range(0, 30)), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mdiv_host_seq.md
# mdiv_host_seq

Host-side sequencer placed directly upstream of the modular inverse/division core (`MINV_MDIV`), with its result readout downstream of that core. It takes parallel 256-bit operands and a mode bit, then streams `p`, `a` and optionally `b` into the core 32 bits per cycle. It fires the start pulse, waits for ready with a watchdog, and drains the result register indicated by the core's flag back into a parallel 256-bit result.

## Interface
- `WORDS`, 8: 32-bit words per operand (256/32).
- `TIMEOUT`, 4096: max cycles waited for core ready before error.
- `clk` in 1: clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request, honoured only in IDLE.
- `mode` in 1: 1 = modular inverse a^-1 mod p; 0 = modular division b·a^-1 mod p.
- `op_a`, `op_b`, `op_p` in 256 each: operands, latched on accepted `start`.
- `busy` out 1: high from accepted `start` until the cycle after `done`.
- `done` out 1: one-cycle pulse at completion.
- `err` out 1: set by timeout, held until next accepted `start`.
- `result` out 256: assembled result, held until overwritten.
- `datain` out 32: word to core.
- `loada`, `loadb`, `loadp` out 1: per-word load strobes to core.
- `minv_mdiv` out 1: mode to core, equal to latched `mode` while busy.
- `minv_mdiv_en` out 1: one-cycle start pulse to core.
- `outx1`, `outx2` out 1: result-register shift strobes to core.
- `regx1out`, `regx2out` in 32 each: low word of the core's x1/x2 registers.
- `minv_mdiv_rdy`, `minv_mdiv_flag` in 1: core done, and result location (0 = x1, 1 = x2).

## Operation
- States: IDLE → LD_P → LD_A → [LD_B if mode=0] → GO → WAIT → RD → FIN → IDLE.
- IDLE: `start`=1 latches the operands and mode, clears `err` and the word counter, and moves to LD_P. `start` in any other state is ignored.
- LD_P/LD_A/LD_B: each lasts `WORDS` cycles. Word k (k=0..7, least-significant first) drives `datain` = op[32k+31:32k], with the matching strobe high for exactly those 8 cycles. After k=7 the counter wraps to 0 and the next state begins. Strobes are never high together. `datain`=0 when no strobe is high.
- LD_A exits to LD_B when mode=0 and to GO when mode=1. `loadb` never rises in inverse mode.
- GO: `minv_mdiv_en`=1 for one cycle. The timeout counter is cleared.
- WAIT: `minv_mdiv_rdy` is ignored in the first WAIT cycle, to avoid a stale ready. From the second cycle on, rdy=1 latches `minv_mdiv_flag` into `sel` and moves to RD. If the timeout counter reaches `TIMEOUT-1` without rdy, `err` is set and the state goes to FIN, leaving `result` untouched.
- RD: `WORDS` cycles. In cycle k, `result[32k+31:32k]` ← (`sel` ? `regx2out` : `regx1out`). In the same cycle `outx2` (if sel) or `outx1` (if not) is high so the core shifts right by 32 bits for the next cycle. Only one of outx1/outx2 is ever high.
- FIN: `done`=1 for one cycle, then IDLE.
- Reset mid-operation: all state is abandoned immediately and all strobes drop asynchronously. The core must be re-loaded by the next `start`.

## Timing
- Reset values: state IDLE; `busy`, `done`, `err`, all strobes, `minv_mdiv_en`, `minv_mdiv` = 0; `datain`=0; `result`=0; counters=0.
- All outputs are registered. A `start` sampled at edge 0 gives `loadp`=1 in cycles 1..8 and `loada`=1 in cycles 9..16.
- Inverse mode: `minv_mdiv_en` in cycle 17. Division mode: `loadb` in cycles 17..24 and `minv_mdiv_en` in cycle 25.
- If rdy is first seen in WAIT cycle w (w≥2), the RD cycles are w+1..w+8 and `done` follows one cycle after the last RD cycle.
- Total overhead excluding core compute is 27 cycles (inverse) or 35 cycles (division).
- `busy` falls in the cycle after `done`. A `start` in that same cycle is accepted.

## Test plan
- Inverse with a=3, p=7 (upper words 0), core flag=0: the strobe sequence matches the cycle counts above, and `result`=5 with `err`=0.
- Division with a=3, b=4, p=7: `loadb` is high for exactly 8 cycles with `datain`=4 on word 0 and 0 elsewhere, then `result`=6.
- Flag=1 path: the core returns its result in x2 with word pattern 0x11111111·(k+1). Only `outx2` pulses, and `result` word k = 0x11111111·(k+1).
- Stale ready: rdy held at 1 across GO and the first WAIT cycle. The block must wait for the second WAIT cycle and must not read during GO.
- Timeout with `TIMEOUT`=16 and rdy never asserted: `err`=1 and `done` is pulsed 16 cycles after entering WAIT. `result` keeps its previous value, and the next `start` clears `err`.
- Asynchronous `rst` pulse during LD_A word 4, plus `start` asserted while busy: all outputs return to their reset values at once, and the while-busy `start` has no effect.
